// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential PC generation, pipelined in-order imem reads, and a DEPTH-entry
// instruction queue toward decode, with branch redirect that flushes and squashes stale reads.
module fetch_queue_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 'h3000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_fetch,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_rd,
  output logic [PC_W-1:0]            imem_addr,
  input  logic                       imem_rvalid,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_npc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  // Stale responses can pile up across repeated redirects with a slow memory, so the
  // drop counter gets extra headroom beyond a single queue's worth of credit.
  localparam int DROP_W = CNT_W + 4;

  logic [PC_W-1:0]    pc;
  logic [CNT_W-1:0]   inflight;
  logic [DROP_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]   q_wr, q_rd, tag_wr, tag_rd;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [PC_W-1:0]    tag_mem [DEPTH];

  logic credit_ok, issue, drop, push, pop;

  // Credit counts queued plus in-flight entries from registered state only, so a pop
  // this cycle frees a slot for issue one cycle later.
  assign credit_ok = ({1'b0, q_count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
  assign imem_rd   = en_fetch & ~redirect & ~rst & credit_ok;
  assign imem_addr = pc;
  assign issue     = imem_rd;

  assign drop      = imem_rvalid & (drop_cnt != '0);
  assign push      = imem_rvalid & (drop_cnt == '0) & ~redirect & ~rst;

  assign out_valid = ~rst & (q_count != '0);
  assign pop       = out_valid & out_ready & ~redirect;

  assign out_instr = q_instr[q_rd];
  assign out_pc    = q_pc[q_rd];
  assign out_npc   = out_pc + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      q_count  <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      q_count  <= '0;
      inflight <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      // Every read still outstanding becomes stale; a response landing now is one of them.
      drop_cnt <= drop_cnt + DROP_W'(inflight) - DROP_W'(imem_rvalid);
    end else begin
      if (issue) begin
        pc     <= pc + 1'b1;
        tag_wr <= tag_wr + 1'b1;
      end
      if (drop) drop_cnt <= drop_cnt - 1'b1;
      if (push) begin
        q_wr   <= q_wr + 1'b1;
        tag_rd <= tag_rd + 1'b1;
      end
      if (pop) q_rd <= q_rd + 1'b1;
      q_count  <= q_count + CNT_W'(push) - CNT_W'(pop);
      inflight <= inflight + CNT_W'(issue) - CNT_W'(push);

      assert (!(imem_rvalid && inflight == '0 && drop_cnt == '0));
      assert (q_count <= CNT_W'(DEPTH));
    end
  end

  // NOTE: the storage arrays carry no reset; pointers and counts are reset, so stale
  // contents are never observable and the arrays can map onto plain register files.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr] <= pc;
    if (push) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc[q_wr]    <= tag_mem[tag_rd];
    end
  end

endmodule
